// File: rtl/seq_pkg.sv
// seq_pkg: state encodings and defaults shared by the serializer, detector and bench
package seq_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_t;
  localparam int DEF_WIDTH = 8;
endpackage

// File: rtl/bit_serializer.sv
// bit_serializer: valid/ready parallel-to-serial front end with a one-word holding buffer
module bit_serializer
  import seq_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             out,
  output logic             out_valid,
  output logic             out_last,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  state_t state, state_n;
  logic [WIDTH-1:0] shreg, shreg_n, hold, hold_n;
  logic [CW-1:0] cnt, cnt_n;
  logic hold_full, hold_full_n, accept, last, out_n, out_last_n;
  assign accept = din_valid & din_ready;
  assign last   = (state == ST_SHIFT) && (cnt == CW'(WIDTH - 1));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      shreg     <= '0;
      hold      <= '0;
      cnt       <= '0;
      hold_full <= 1'b0;
      out       <= IDLE_LEVEL;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      din_ready <= 1'b1;
    end else begin
      state     <= state_n;
      shreg     <= shreg_n;
      hold      <= hold_n;
      cnt       <= cnt_n;
      hold_full <= hold_full_n;
      out       <= out_n;
      out_valid <= state_n == ST_SHIFT;
      out_last  <= out_last_n;
      busy      <= (state_n == ST_SHIFT) | hold_full_n;
      din_ready <= ~hold_full_n;
    end
  end
  // at the last-bit edge the held word wins over a bypass so word order is kept
  always_comb begin
    state_n     = state;
    shreg_n     = shreg;
    hold_n      = hold;
    cnt_n       = cnt;
    hold_full_n = hold_full;
    if (state == ST_IDLE) begin
      if (accept) begin
        state_n = ST_SHIFT;
        shreg_n = din;
        cnt_n   = '0;
      end
    end else if (last) begin
      cnt_n = '0;
      if (hold_full) begin
        shreg_n     = hold;
        hold_full_n = 1'b0;
      end else if (accept) shreg_n = din;
      else state_n = ST_IDLE;
    end else begin
      cnt_n   = cnt + 1'b1;
      shreg_n = MSB_FIRST ? shreg << 1 : shreg >> 1;
      if (accept) begin
        hold_n      = din;
        hold_full_n = 1'b1;
      end
    end
  end
  always_comb begin
    out_n      = (state_n == ST_SHIFT) ? (MSB_FIRST ? shreg_n[WIDTH-1] : shreg_n[0]) : IDLE_LEVEL;
    out_last_n = (state_n == ST_SHIFT) && (cnt_n == CW'(WIDTH - 1));
  end
endmodule
